motion_alarm_ctrl: RTL and testbench

Central controller for the three-zone PIR motion detector. It synchronizes and qualifies the raw pir_sensor_1..3 inputs, and sequences arm, exit-delay, entry-delay and alarm states. It also shares a single zone-report channel among the three zones using round-robin arbitration. It sits between the sensor pins / stop_alarm button and the siren driver and status logger.

---
 rtl/motion_pkg.sv | 42 ++++
 rtl/motion_alarm_ctrl_if.sv | 24 ++
 rtl/pir_qualifier.sv | 37 +++
 rtl/motion_alarm_ctrl.sv | 133 +++++++++++++
 tb/tb_motion_alarm_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/motion_pkg.sv
// Shared types and helpers for the three-zone PIR motion alarm controller.
package motion_pkg;

  typedef enum logic [2:0] {
    DISARMED,
    ARMING,
    ARMED,
    ENTRY,
    ALARM
  } state_t;

  localparam int NUM_ZONES = 3;
  localparam int ZONE_ID_W = 2;

  // Width needed to hold (largest delay - 1), never narrower than one bit.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Round-robin pick: first requesting zone searching upward from ptr+1 (mod NUM_ZONES).
  function automatic logic [ZONE_ID_W-1:0] rr_pick(input logic [NUM_ZONES-1:0] req,
                                                   input logic [ZONE_ID_W-1:0] ptr);
    logic [ZONE_ID_W-1:0] pick;
    logic                 found;
    int                   z;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_ZONES; k++) begin
      z = (int'(ptr) + k) % NUM_ZONES;
      if (!found && req[z[ZONE_ID_W-1:0]]) begin
        pick  = z[ZONE_ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/motion_alarm_ctrl_if.sv
// Sensor, control and zone-report signals of the motion alarm controller.
interface motion_alarm_ctrl_if;
  import motion_pkg::*;

  logic                 arm;
  logic                 stop_alarm;
  logic                 pir_sensor_1;
  logic                 pir_sensor_2;
  logic                 pir_sensor_3;
  logic                 armed;
  logic                 alarm;
  logic                 zone_valid;
  logic [ZONE_ID_W-1:0] zone_id;

  modport master (
    output arm, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    input  armed, alarm, zone_valid, zone_id
  );

  modport slave (
    input  arm, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    output armed, alarm, zone_valid, zone_id
  );
endinterface

// File: rtl/pir_qualifier.sv
// Per-zone PIR conditioning: 2-flop synchronizer, saturating run counter and
// a one-cycle trip pulse once the input has been high for MIN_PULSE cycles.
module pir_qualifier #(
  parameter int MIN_PULSE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pir,
  output logic trip
);

  localparam int CNT_W = $clog2(MIN_PULSE + 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] run_cnt;

  // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      run_cnt <= '0;
    end else begin
      sync_1 <= pir;
      sync_2 <= sync_1;
      if (!sync_2)
        run_cnt <= '0;
      else if (run_cnt != CNT_W'(MIN_PULSE))
        run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  // Fires in the cycle the counter is about to saturate; saturation blocks re-trips.
  assign trip = sync_2 && (run_cnt == CNT_W'(MIN_PULSE - 1));

endmodule

// File: rtl/motion_alarm_ctrl.sv
// Three-zone PIR alarm controller: arm/exit/entry/alarm sequencing plus a
// round-robin zone-report channel. Define ALARM_LATCH_EN to disable auto-silence.
module motion_alarm_ctrl
  import motion_pkg::*;
#(
  parameter int ARM_DELAY     = 16,
  parameter int ENTRY_DELAY   = 8,
  parameter int ALARM_TIMEOUT = 64,
  parameter int MIN_PULSE     = 1
) (
  input logic                clk,
  input logic                rst_n,
  motion_alarm_ctrl_if.slave bus
);

  localparam int TIMER_W = timer_w(ARM_DELAY, ENTRY_DELAY, ALARM_TIMEOUT);
`ifdef ALARM_LATCH_EN
  localparam bit LATCH_ALARM = 1'b1;
`else
  localparam bit LATCH_ALARM = 1'b0;
`endif

  state_t                 state, state_n;
  logic [TIMER_W-1:0]     timer, timer_n;
  logic [NUM_ZONES-1:0]   pending, pending_n;
  logic [ZONE_ID_W-1:0]   pointer, pointer_n;
  logic                   zone_valid_q, zone_valid_n;
  logic [ZONE_ID_W-1:0]   zone_id_q, zone_id_n;

  logic [NUM_ZONES-1:0]   pir_raw;
  logic [NUM_ZONES-1:0]   trip;
  logic [NUM_ZONES-1:0]   grant_mask;
  logic [ZONE_ID_W-1:0]   grant_zone;
  logic                   leaving;

  assign pir_raw = {bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1};

  for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
    pir_qualifier #(.MIN_PULSE(MIN_PULSE)) u_qual (
      .clk  (clk),
      .rst_n(rst_n),
      .pir  (pir_raw[i]),
      .trip (trip[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= DISARMED;
      timer        <= '0;
      pending      <= '0;
      pointer      <= ZONE_ID_W'(2);
      zone_valid_q <= 1'b0;
      zone_id_q    <= '0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      pending      <= pending_n;
      pointer      <= pointer_n;
      zone_valid_q <= zone_valid_n;
      zone_id_q    <= zone_id_n;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_n      = state;
    timer_n      = timer;
    pointer_n    = pointer;
    zone_valid_n = 1'b0;
    zone_id_n    = zone_id_q;
    grant_mask   = '0;

    case (state)
      DISARMED: if (bus.arm) begin
        state_n = ARMING;
        timer_n = TIMER_W'(ARM_DELAY - 1);
      end
      ARMING: begin
        if (!bus.arm)         state_n = DISARMED;
        else if (timer == '0) state_n = ARMED;
        else                  timer_n = timer - TIMER_W'(1);
      end
      ARMED: begin
        if (!bus.arm) state_n = DISARMED;
        else if (|pending) begin
          state_n = ENTRY;
          timer_n = TIMER_W'(ENTRY_DELAY - 1);
        end
      end
      ENTRY: begin
        if (!bus.arm)            state_n = DISARMED;
        else if (bus.stop_alarm) state_n = ARMED;
        else if (timer == '0) begin
          state_n = ALARM;
          if (!LATCH_ALARM) timer_n = TIMER_W'(ALARM_TIMEOUT - 1);
        end else                 timer_n = timer - TIMER_W'(1);
      end
      ALARM: begin
        if (!bus.arm)            state_n = DISARMED;
        else if (bus.stop_alarm) state_n = ARMED;
        else if (!LATCH_ALARM) begin
          if (timer == '0) state_n = ARMED;
          else             timer_n = timer - TIMER_W'(1);
        end
      end
      default: state_n = DISARMED;
    endcase

    // Dropping back to DISARMED/ARMED flushes all outstanding reports.
    leaving    = (state_n != state) && (state_n == DISARMED || state_n == ARMED);
    grant_zone = rr_pick(pending, pointer);
    if ((state == ENTRY || state == ALARM) && (|pending) && !leaving) begin
      grant_mask   = NUM_ZONES'(1) << grant_zone;
      zone_valid_n = 1'b1;
      zone_id_n    = grant_zone;
      pointer_n    = grant_zone;
    end

    if (leaving)
      pending_n = '0;
    else if (state == ARMED || state == ENTRY || state == ALARM)
      pending_n = (pending & ~grant_mask) | trip;
    else
      pending_n = pending & ~grant_mask;
  end

  assign bus.armed      = (state == ARMED) || (state == ENTRY) || (state == ALARM);
  assign bus.alarm      = (state == ALARM);
  assign bus.zone_valid = zone_valid_q;
  assign bus.zone_id    = zone_id_q;

endmodule

// File: tb/tb_motion_alarm_ctrl.sv
// Self-checking bench for motion_alarm_ctrl: directed scenarios plus random
// stimulus, all compared each cycle against a behavioural model.
module tb_motion_alarm_ctrl;

  localparam int ARM_DELAY     = 16;
  localparam int ENTRY_DELAY   = 8;
  localparam int ALARM_TIMEOUT = 64;
  localparam int MIN_PULSE     = 1;
`ifdef ALARM_LATCH_EN
  localparam bit LATCHED = 1'b1;
`else
  localparam bit LATCHED = 1'b0;
`endif

  localparam int S_DIS = 0, S_ARMING = 1, S_ARMED = 2, S_ENTRY = 3, S_ALARM = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  motion_alarm_ctrl_if bus();

  motion_alarm_ctrl #(
    .ARM_DELAY    (ARM_DELAY),
    .ENTRY_DELAY  (ENTRY_DELAY),
    .ALARM_TIMEOUT(ALARM_TIMEOUT),
    .MIN_PULSE    (MIN_PULSE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Behavioural model: state plus cycles-spent-in-state, raw sample history per zone.
  int m_st, m_age, m_ptr, m_zid;
  bit m_zv;
  bit m_pend [3];
  bit hist0  [3];
  bit hist1  [3];
  int hi_run [3];

  function automatic void model_reset();
    m_st = S_DIS; m_age = 0; m_ptr = 2; m_zid = 0; m_zv = 1'b0;
    for (int z = 0; z < 3; z++) begin
      m_pend[z] = 1'b0; hist0[z] = 1'b0; hist1[z] = 1'b0; hi_run[z] = 0;
    end
  endfunction

  function automatic void model_step();
    bit a, s, leaving, any_pend;
    bit raw [3];
    bit trp [3];
    int nxt, g;
    a = bus.arm; s = bus.stop_alarm;
    raw[0] = bus.pir_sensor_1; raw[1] = bus.pir_sensor_2; raw[2] = bus.pir_sensor_3;
    for (int z = 0; z < 3; z++) begin
      hi_run[z] = hist1[z] ? hi_run[z] + 1 : 0;
      trp[z]    = (hi_run[z] == MIN_PULSE);
      hist1[z]  = hist0[z];
      hist0[z]  = raw[z];
    end
    any_pend = m_pend[0] | m_pend[1] | m_pend[2];
    nxt = m_st;
    case (m_st)
      S_DIS:    if (a) nxt = S_ARMING;
      S_ARMING: if (!a) nxt = S_DIS; else if (m_age == ARM_DELAY - 1) nxt = S_ARMED;
      S_ARMED:  if (!a) nxt = S_DIS; else if (any_pend) nxt = S_ENTRY;
      S_ENTRY:  if (!a) nxt = S_DIS; else if (s) nxt = S_ARMED;
                else if (m_age == ENTRY_DELAY - 1) nxt = S_ALARM;
      S_ALARM:  if (!a) nxt = S_DIS; else if (s) nxt = S_ARMED;
                else if (!LATCHED && m_age == ALARM_TIMEOUT - 1) nxt = S_ARMED;
      default:  nxt = S_DIS;
    endcase
    leaving = (nxt != m_st) && (nxt == S_DIS || nxt == S_ARMED);
    m_zv = 1'b0;
    g = -1;
    if ((m_st == S_ENTRY || m_st == S_ALARM) && any_pend && !leaving)
      for (int k = 1; k <= 3; k++)
        if (g < 0 && m_pend[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
    if (g >= 0) begin
      m_zv = 1'b1; m_zid = g; m_ptr = g; m_pend[g] = 1'b0;
    end
    for (int z = 0; z < 3; z++)
      if (m_st >= S_ARMED && trp[z]) m_pend[z] = 1'b1;
    if (leaving)
      for (int z = 0; z < 3; z++) m_pend[z] = 1'b0;
    m_age = (nxt == m_st) ? m_age + 1 : 0;
    m_st  = nxt;
  endfunction

  task automatic check_outputs();
    check("armed",      bus.armed,      32'(m_st >= S_ARMED));
    check("alarm",      bus.alarm,      32'(m_st == S_ALARM));
    check("zone_valid", bus.zone_valid, 32'(m_zv));
    check("zone_id",    bus.zone_id,    32'(m_zid));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_pir(input bit [2:0] v);
    bus.pir_sensor_1 = v[0];
    bus.pir_sensor_2 = v[1];
    bus.pir_sensor_3 = v[2];
  endtask

  // Called at a falling edge: asynchronous reset mid-cycle, released one cycle later.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_armed",      bus.armed,      0);
    check("rst_alarm",      bus.alarm,      0);
    check("rst_zone_valid", bus.zone_valid, 0);
    check("rst_zone_id",    bus.zone_id,    0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int n = 0;
    while (m_st != st && n < budget) begin
      tick();
      n++;
    end
    check(tag, m_st, st);
  endtask

  task automatic trip_zone(input bit [2:0] v);
    set_pir(v);
    repeat (3) tick();
    set_pir(3'b000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int zv_cnt, alarm_cnt, first_alarm;
    int ids[$];

    bus.arm = 1'b0; bus.stop_alarm = 1'b0; set_pir(3'b000);
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    check("init_zone_id", bus.zone_id, 0);
    rst_n = 1'b1;

    // Exit delay; a PIR pulse while arming must be discarded.
    bus.arm = 1'b1;
    zv_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      if (i == 3) set_pir(3'b001);
      if (i == 5) set_pir(3'b000);
      tick();
      zv_cnt += int'(bus.zone_valid);
      if (i == 15) check("exit_not_done", bus.armed, 0);
    end
    check("exit_done", bus.armed, 1);
    repeat (6) begin tick(); zv_cnt += int'(bus.zone_valid); end
    check("arming_trip_ignored", zv_cnt, 0);

    // Single-zone trip: entry delay, alarm, auto-silence (or latch).
    zv_cnt = 0; alarm_cnt = 0; first_alarm = -1;
    set_pir(3'b001);
    for (int i = 0; i < 100; i++) begin
      if (i == 3) set_pir(3'b000);
      tick();
      zv_cnt    += int'(bus.zone_valid);
      alarm_cnt += int'(bus.alarm);
      if (bus.alarm && first_alarm < 0) first_alarm = i + 1;
    end
    check("one_report", zv_cnt, 1);
    check("alarm_edge", first_alarm, 12);
    check("alarm_cycles", alarm_cnt, LATCHED ? 89 : 64);
    check("armed_after", bus.armed, 1);
    repeat (200) tick();
    check("alarm_hold", bus.alarm, 32'(LATCHED));
    bus.stop_alarm = 1'b1; tick(); bus.stop_alarm = 1'b0;
    check("stop_clears", bus.alarm, 0);

    // Three simultaneous zones, reported 0,1,2 twice from a fresh pointer.
    do_reset();
    repeat (17) tick();
    for (int pass = 0; pass < 2; pass++) begin
      ids.delete();
      set_pir(3'b111);
      for (int i = 0; i < 12; i++) begin
        if (i == 3) set_pir(3'b000);
        tick();
        if (bus.zone_valid) ids.push_back(int'(bus.zone_id));
      end
      check("rr_count", ids.size(), 3);
      for (int k = 0; k < 3 && k < ids.size(); k++) check("rr_order", ids[k], k);
      bus.stop_alarm = 1'b1; tick(); bus.stop_alarm = 1'b0;
      repeat (5) tick();
    end

    // Stop during entry delay.
    trip_zone(3'b010);
    wait_state(S_ENTRY, 10, "reach_entry");
    repeat (3) tick();
    bus.stop_alarm = 1'b1; tick(); bus.stop_alarm = 1'b0;
    check("entry_cancel_armed", bus.armed, 1);
    alarm_cnt = 0;
    repeat (20) begin tick(); alarm_cnt += int'(bus.alarm); end
    check("entry_cancel_no_alarm", alarm_cnt, 0);

    // Stop during alarm.
    trip_zone(3'b100);
    wait_state(S_ALARM, 30, "reach_alarm");
    check("alarm_on", bus.alarm, 1);
    bus.stop_alarm = 1'b1; tick(); bus.stop_alarm = 1'b0;
    check("alarm_stopped", bus.alarm, 0);

    // Disarm beats stop in alarm.
    trip_zone(3'b001);
    wait_state(S_ALARM, 30, "reach_alarm2");
    bus.arm = 1'b0; bus.stop_alarm = 1'b1; tick();
    check("disarm_armed", bus.armed, 0);
    check("disarm_alarm", bus.alarm, 0);
    bus.arm = 1'b1; bus.stop_alarm = 1'b0;

    // Asynchronous reset in the middle of an alarm.
    wait_state(S_ARMED, 30, "rearm");
    trip_zone(3'b010);
    wait_state(S_ALARM, 30, "reach_alarm3");
    repeat (2) tick();
    do_reset();

    // Random stimulus.
    for (int n = 0; n < 20000; n++) begin
      if (bus.arm) bus.arm = ($urandom_range(0, 399) != 0);
      else         bus.arm = ($urandom_range(0, 7) == 0);
      bus.stop_alarm = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) bus.pir_sensor_1 = ~bus.pir_sensor_1;
      if ($urandom_range(0, 9) == 0) bus.pir_sensor_2 = ~bus.pir_sensor_2;
      if ($urandom_range(0, 9) == 0) bus.pir_sensor_3 = ~bus.pir_sensor_3;
      if ($urandom_range(0, 4999) == 0) do_reset();
      else                              tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
